riscv_multicycle_core: RTL
==========================

RISCV_MULTICYCLE_CORE -- requirements
Module: riscv_multicycle_core

Interface
REQ-001 Parameter XLEN, default 32, datapath, register and address width; only 32 is legal.
REQ-002 Parameter NREGS, default 32, number of architectural registers; 16 (RV32E) or 32 are legal.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 a_rst  in  1  asynchronous, active-high reset.
REQ-006 mem_req  out  1  memory transfer request.
REQ-007 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 mem_addr  out  XLEN  byte address, word aligned.
REQ-009 mem_wdata  out  XLEN  store data; valid while mem_req=1 and mem_we=1.
REQ-010 mem_rdata  in  XLEN  read data; sampled in the cycle mem_req=1 and mem_ready=1.
REQ-011 mem_ready  in  1  transfer completes in any cycle with mem_req=1 and mem_ready=1.
REQ-012 retire  out  1  one-cycle pulse per completed instruction.
REQ-013 halted  out  1  core stopped in TRAP.
REQ-014 pc_o  out  XLEN  current PC register.

Function
REQ-015 The core SHALL execute lw, sw, addi, beq and R-type add/sub/and/or/slt; every other encoding SHALL trap.
REQ-016 Legal encodings: add (funct3 000, funct7 0000000), sub (000/0100000), slt (010/0000000, signed), or (110/0000000), and (111/0000000); addi, beq: funct3 000; lw, sw: funct3 010.
REQ-017 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, TRAP.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on completion IR<=mem_rdata, old_pc<=pc, pc<=pc+4 mod 2^XLEN, go to DECODE; otherwise hold.
REQ-019 DECODE: A<=rs1, B<=rs2, ALUOut<=old_pc+immB; go to MEMADR (lw/sw), EXECR, EXECI, BEQ, or TRAP (illegal).
REQ-020 MEMADR: ALUOut<=A+immI (lw) or A+immS (sw); if ALUOut[1:0]!=0 go to TRAP with no request issued, else go to MEMREAD or MEMWRITE.
REQ-021 MEMREAD: read request at ALUOut; on completion Data<=mem_rdata, go to MEMWB. MEMWB: rd<=Data, retire, go to FETCH.
REQ-022 MEMWRITE: write request at ALUOut with wdata=B; on completion retire, go to FETCH.
REQ-023 EXECR: ALUOut<=A op B. EXECI: ALUOut<=A+immI. Both go to ALUWB. ALUWB: rd<=ALUOut, retire, go to FETCH.
REQ-024 BEQ: if A==B then pc<=ALUOut; if the taken target has bits [1:0]!=0 go to TRAP without retire; otherwise retire and go to FETCH.
REQ-025 TRAP: halted=1, mem_req=0, and the core stays in TRAP until reset.
REQ-026 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-027 Latency with mem_ready held at 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3; each mem_ready=0 cycle during a request adds exactly one cycle.
REQ-028 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-029 With NREGS=16, any rs1, rs2 or rd index >=16 SHALL trap in DECODE.
REQ-030 All arithmetic SHALL wrap modulo 2^XLEN; slt SHALL return 1 or 0, zero-extended.
REQ-031 A register write and an operand read of the same register never coincide, because writeback and DECODE are different states; the register file needs no bypass.

Reset
REQ-032 While a_rst=1: state=FETCH, pc=RESET_PC, all registers 0, mem_req=0, retire=0, halted=0.
REQ-033 The first FETCH request SHALL be issued in the first clock cycle after a_rst deasserts.
REQ-034 Asserting a_rst mid-transfer SHALL drop mem_req in the same cycle (asynchronously); no retire follows.

Verification
REQ-035 Program "addi x1,x0,5; addi x2,x0,7; add x3,x1,x2", ready=1 -> x3=12, 3 retire pulses in 12 cycles, pc_o=12.
REQ-036 "sw x3,8(x0); lw x4,8(x0)" with mem_ready low for 2 cycles on each transfer -> write of 12 to address 8, x4=12, addr/wdata stable during stalls.
REQ-037 beq x1,x1,-8 at pc 16 -> pc_o=8 after 3 cycles; beq x1,x2 (5 vs 7) -> pc_o=20.
REQ-038 Instruction 32'hFFFF_FFFF, or lw at address 2 -> halted=1, no further mem_req, retire=0.
REQ-039 "addi x0,x0,9", then "sub x5,x0,x1" with x1=5 -> x0 reads 0, x5=32'hFFFF_FFFB; slt(-1,1)=1.
REQ-040 a_rst pulsed during a MEMREAD stall -> mem_req=0 immediately; after release, fetch from RESET_PC.

Source files
------------

// File: rtl/riscv_multicycle_core.sv
// Multicycle RV32I subset core (lw, sw, addi, beq, add/sub/and/or/slt) with a
// single shared memory port; anything outside the subset halts the core in TRAP.
module riscv_multicycle_core #(
  parameter int               XLEN     = 32,
  parameter int               NREGS    = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            a_rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            retire,
  output logic            halted,
  output logic [XLEN-1:0] pc_o,
  output logic [3:0]      dbg_state
);

  // Memory handshake: a transfer completes in any cycle where mem_req and
  // mem_ready are both high; until then addr/we/wdata are held from flops.

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_TRAP
  } state_t;

  localparam int RIDX = (NREGS > 16) ? 5 : 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, old_pc_q, old_pc_d, ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, alu_q, alu_d, data_q, data_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [4:0]        rd_f, rs1_f, rs2_f;
  logic [RIDX-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, alu_r, ea;
  logic              rf_we, req_c, retire_c;
  logic [XLEN-1:0]   rf_wd;
  logic              dec_legal, uses_rd, uses_rs1, uses_rs2, bad_idx;
  state_t            dec_next;

  assign opcode  = ir_q[6:0];
  assign rd_f    = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1_f   = ir_q[19:15];
  assign rs2_f   = ir_q[24:20];
  assign funct7  = ir_q[31:25];
  assign rd_idx  = rd_f[RIDX-1:0];
  assign rs1_idx = rs1_f[RIDX-1:0];
  assign rs2_idx = rs2_f[RIDX-1:0];

  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  // Instruction classification and legality, consumed only in DECODE.
  always_comb begin
    dec_legal = 1'b0;
    dec_next  = S_TRAP;
    uses_rd   = 1'b0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    case (opcode)
      OP_LOAD:  begin dec_legal = (funct3 == 3'b010); dec_next = S_MEMADR; uses_rd = 1'b1; end
      OP_STORE: begin dec_legal = (funct3 == 3'b010); dec_next = S_MEMADR; uses_rs2 = 1'b1; end
      OP_IMM:   begin dec_legal = (funct3 == 3'b000); dec_next = S_EXECI; uses_rd = 1'b1; end
      OP_BR:    begin dec_legal = (funct3 == 3'b000); dec_next = S_BEQ; uses_rs2 = 1'b1; end
      OP_REG: begin
        dec_legal = ((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
                    (((funct3 == 3'b010) || (funct3 == 3'b110) || (funct3 == 3'b111)) &&
                     (funct7 == 7'b0000000));
        dec_next  = S_EXECR;
        uses_rd   = 1'b1;
        uses_rs2  = 1'b1;
      end
      default: uses_rs1 = 1'b0;
    endcase
    bad_idx = 1'b0;
    if (NREGS == 16) begin
      bad_idx = (uses_rd && rd_f[4]) || (uses_rs1 && rs1_f[4]) || (uses_rs2 && rs2_f[4]);
    end
  end

  always_comb begin
    alu_r = a_q + b_q;
    case (funct3)
      3'b000:  alu_r = funct7[5] ? (a_q - b_q) : (a_q + b_q);
      3'b010:  alu_r = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      3'b110:  alu_r = a_q | b_q;
      3'b111:  alu_r = a_q & b_q;
      default: alu_r = a_q + b_q;
    endcase
  end

  assign ea = a_q + ((opcode == OP_STORE) ? imm_s : imm_i);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    old_pc_d  = old_pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    data_d    = data_q;
    rf_we     = 1'b0;
    rf_wd     = alu_q;
    req_c     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    retire_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c    = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d     = mem_rdata;
          old_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = regs_q[rs1_idx];
        b_d     = regs_q[rs2_idx];
        alu_d   = old_pc_q + imm_b;
        state_d = (dec_legal && !bad_idx) ? dec_next : S_TRAP;
      end
      S_MEMADR: begin
        alu_d = ea;
        if (ea[1:0] != 2'b00) state_d = S_TRAP;
        else state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_c    = 1'b1;
        mem_addr = alu_q;
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wd    = data_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = alu_q;
        mem_wdata = b_q;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin alu_d = alu_r; state_d = S_ALUWB; end
      S_EXECI: begin alu_d = a_q + imm_i; state_d = S_ALUWB; end
      S_ALUWB: begin
        rf_we    = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        if (a_q == b_q) pc_d = alu_q;
        if ((a_q == b_q) && (alu_q[1:0] != 2'b00)) begin
          state_d = S_TRAP;
        end else begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (rf_we && (rd_f != 5'd0)) regs_d[rd_idx] = rf_wd;
  end

  // Reset forces the request low combinationally so a transfer in flight
  // is abandoned in the same cycle the reset arrives.
  assign mem_req   = req_c && !a_rst;
  assign retire    = retire_c && !a_rst;
  assign halted    = (state_q == S_TRAP);
  assign pc_o      = pc_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      old_pc_q <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      data_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      data_q   <= data_d;
      regs_q   <= regs_d;
    end
  end

endmodule
